// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS memory-bus arbiter.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D
  } arb_state_t;

  localparam logic [31:0] BUS_ABORT_DATA = 32'hDEADBEEF;
  localparam logic [3:0]  FETCH_BE       = 4'hF;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } avalon_req_t;

endpackage

// File: rtl/mips_bus_watchdog.sv
// Saturating stall counter; flags expiry once TIMEOUT_CYCLES stalled cycles have been seen.
module mips_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic stall,
  output logic expired
);

  localparam int unsigned   CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && stall && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one Avalon-style memory port, with stall watchdog.
module mips_mem_arbiter
  import mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned D_PRIORITY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic [31:0] i_readdata,
  output logic        i_waitrequest,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_byteenable,
  input  logic [31:0] d_writedata,
  output logic [31:0] d_readdata,
  output logic        d_waitrequest,
  output logic [31:0] m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [3:0]  m_byteenable,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  output logic        bus_error
);

  arb_state_t  state, next_state, last_grant;
  avalon_req_t m_req, i_req_s, d_req_s;
  logic        i_req, d_req, d_wins;
  logic        grant_i, grant_d, done, abort, expired;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // With only two requesters both priority settings reduce to strict alternation on conflict.
  assign d_wins = (D_PRIORITY != 0) ? (last_grant != GRANT_D) : (last_grant == GRANT_I);

  assign i_req_s = '{addr: i_address, rd: 1'b1, wr: 1'b0, be: FETCH_BE, wdata: '0};
  assign d_req_s = '{addr: d_address, rd: d_read & ~d_write, wr: d_write,
                     be: d_byteenable, wdata: d_writedata};

  always_comb begin
    next_state    = state;
    i_waitrequest = 1'b1;
    d_waitrequest = 1'b1;
    i_readdata    = '0;
    d_readdata    = '0;
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    done          = 1'b0;
    abort         = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!i_req || d_wins)) begin
          grant_d    = 1'b1;
          next_state = GRANT_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          next_state = GRANT_I;
        end
      end
      GRANT_I: begin
        if (expired || !m_waitrequest) begin
          i_waitrequest = 1'b0;
          i_readdata    = expired ? BUS_ABORT_DATA : m_readdata;
          done          = 1'b1;
          abort         = expired;
          next_state    = IDLE;
        end
      end
      GRANT_D: begin
        if (expired || !m_waitrequest) begin
          d_waitrequest = 1'b0;
          d_readdata    = expired ? BUS_ABORT_DATA : m_readdata;
          done          = 1'b1;
          abort         = expired;
          next_state    = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      m_req      <= '0;
      bus_error  <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_i) begin
        m_req <= i_req_s;
      end else if (grant_d) begin
        m_req <= d_req_s;
      end else if (done) begin
        m_req.rd <= 1'b0;
        m_req.wr <= 1'b0;
      end
      if (done) begin
        last_grant <= state;
      end
      if ((grant_d && d_read && d_write) || abort) begin
        bus_error <= 1'b1;
      end
    end
  end

  assign m_address    = m_req.addr;
  assign m_read       = m_req.rd;
  assign m_write      = m_req.wr;
  assign m_byteenable = m_req.be;
  assign m_writedata  = m_req.wdata;

  mips_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .en     (state != IDLE),
    .clr    (grant_i | grant_d),
    .stall  (m_waitrequest),
    .expired(expired)
  );

endmodule
